vend_fsm_param: RTL and testbench
=================================

Name: vend_fsm_param

Overview:
Parametrised successor to the fixed-price single-product vending FSM. Accepts two coin denominations, accumulates credit in half-unit counts, and dispenses one item when credit reaches PRICE. Returns change as a serial stream of one-unit pulses and supports a cancel/refund request. Tracks on-board stock with a restock input and a sold-out lockout. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
PRICE, 5, item price in credit units (1 unit = half coin)
COIN_SMALL, 1, credit value of pay_half
COIN_LARGE, 2, credit value of pay
CREDIT_W, 4, credit register width; elaboration error unless PRICE-1+COIN_LARGE < 2**CREDIT_W
STOCK_INIT, 8, stock after reset or restock; elaboration error unless STOCK_INIT < 2**STOCK_W
STOCK_W, 4, stock counter width
Legality: PRICE>=1, COIN_LARGE>=COIN_SMALL>=1, otherwise elaboration error.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
pay  in  1  large coin present this cycle (one-cycle pulse per coin)
pay_half  in  1  small coin present this cycle
cancel  in  1  refund request pulse
restock  in  1  reload stock to STOCK_INIT
coke_out  out  1  registered one-cycle dispense pulse
ret  out  1  registered change/refund pulse, one unit per high cycle
coin_rej  out  1  registered one-cycle pulse: a coin offered this cycle was not accepted
credit  out  CREDIT_W  current credit (registered)
stock  out  STOCK_W  items remaining (registered)
sold_out  out  1  stock==0 (combinational from stock register)
busy  out  1  state==REFUND

Behaviour:
- Reset (async, rst=1): state=COLLECT, credit=0, stock=STOCK_INIT, coke_out=0, ret=0, coin_rej=0. Any change owed at reset is discarded.
- States: COLLECT (accepting coins), REFUND (paying out credit, one unit per cycle).
- COLLECT, per cycle, priority order:
  1. cancel=1 and credit>0: state<=REFUND. Any coin this cycle is rejected (coin_rej<=1). cancel with credit==0 is a no-op.
  2. sold_out=1: any coin is rejected, credit unchanged.
  3. pay=1: add COIN_LARGE. If pay_half=1 in the same cycle, that small coin is rejected (coin_rej<=1).
  4. Else pay_half=1: add COIN_SMALL.
  - Let sum = credit + accepted value. If sum>=PRICE: coke_out<=1, stock<=stock-1, credit<=sum-PRICE, and state<=REFUND if sum-PRICE>0, else COLLECT. Otherwise credit<=sum.
  - Latency: a completing coin in cycle N gives coke_out high in N+1 and the first change ret in N+2.
- REFUND, per cycle: ret<=1, credit<=credit-1; when credit==1, state<=COLLECT (ret is high for exactly the owed count, in consecutive cycles). All coins are rejected. cancel is ignored.
- Outputs coke_out, ret and coin_rej default to 0 each cycle unless set above.
- restock=1: stock<=STOCK_INIT. This overrides a same-cycle decrement. It is accepted in any state.
- Credit never exceeds PRICE-1+COIN_LARGE. No wrap is possible under the legality checks.
- Stock never decrements below 0, because coins are rejected while sold_out.

Test Plan:
1. Defaults, from reset: pay_half x5 on consecutive cycles -> credit 1,2,3,4; on the 5th coin coke_out=1 the next cycle, credit=0, stock=7, ret never high.
2. credit=4, pay -> coke_out pulse in N+1, credit=1, ret high for 1 cycle in N+2, busy high for that 1 cycle, then COLLECT with credit=0.
3. credit=3, cancel -> ret high for 3 consecutive cycles, credit steps 2,1,0; a pay offered during refund -> coin_rej pulse, credit unaffected.
4. pay and pay_half in the same cycle from credit=0 -> credit=2, coin_rej=1 for one cycle.
5. STOCK_INIT=1: vend once -> sold_out=1; pay -> coin_rej, credit stays 0; restock -> stock=1, sold_out=0, next coins accepted.
6. rst asserted during REFUND with 2 units owed -> ret=0, credit=0 and state=COLLECT immediately (asynchronous); no further ret after release.

Source files
------------

// File: rtl/vend_fsm_param.sv
// Parametrised single-product vending controller.
// Accumulates credit from two coin sizes, dispenses one item when credit
// reaches PRICE, pays change or refunds one unit per cycle, and tracks
// on-board stock with a restock input and a sold-out lockout.
module vend_fsm_param #(
    parameter int PRICE      = 5,
    parameter int COIN_SMALL = 1,
    parameter int COIN_LARGE = 2,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pay,
    input  logic                pay_half,
    input  logic                cancel,
    input  logic                restock,
    output logic                coke_out,
    output logic                ret,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out,
    output logic                busy
);

    // Reject illegal parameter combinations at elaboration time.
    if (PRICE < 1 || COIN_SMALL < 1 || COIN_LARGE < COIN_SMALL) begin : g_bad_price_coins
        $error("vend_fsm_param: need PRICE>=1 and COIN_LARGE>=COIN_SMALL>=1");
    end
    if (PRICE - 1 + COIN_LARGE >= 2 ** CREDIT_W) begin : g_bad_credit_w
        $error("vend_fsm_param: CREDIT_W too small for PRICE-1+COIN_LARGE");
    end
    if (STOCK_INIT >= 2 ** STOCK_W) begin : g_bad_stock_w
        $error("vend_fsm_param: STOCK_W too small for STOCK_INIT");
    end

    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]   PRICE_V = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0]   LARGE_V = SUM_W'(COIN_LARGE);
    localparam logic [SUM_W-1:0]   SMALL_V = SUM_W'(COIN_SMALL);
    localparam logic [STOCK_W-1:0] STOCK_V = STOCK_W'(STOCK_INIT);

    typedef enum logic [0:0] {
        ST_COLLECT,
        ST_REFUND
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                coke_out_q, coke_out_d;
    logic                ret_q, ret_d;
    logic                coin_rej_q, coin_rej_d;

    logic [SUM_W-1:0]    add_val;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    change;
    logic                coin_any;

    assign coin_any = pay | pay_half;
    assign sold_out = (stock_q == '0);

    // Next-state, credit, stock and pulse outputs for the coming cycle.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        stock_d    = stock_q;
        coke_out_d = 1'b0;
        ret_d      = 1'b0;
        coin_rej_d = 1'b0;
        add_val    = '0;
        sum        = '0;
        change     = '0;

        case (state_q)
            ST_COLLECT: begin
                if (cancel && credit_q != '0) begin
                    state_d    = ST_REFUND;
                    coin_rej_d = coin_any;
                end else if (sold_out) begin
                    coin_rej_d = coin_any;
                end else begin
                    // Large coin wins; a simultaneous small coin is bounced.
                    if (pay) begin
                        add_val    = LARGE_V;
                        coin_rej_d = pay_half;
                    end else if (pay_half) begin
                        add_val    = SMALL_V;
                    end
                    sum = {1'b0, credit_q} + add_val;
                    if (sum >= PRICE_V) begin
                        change     = sum - PRICE_V;
                        coke_out_d = 1'b1;
                        stock_d    = stock_q - STOCK_W'(1);
                        credit_d   = CREDIT_W'(change);
                        if (change != '0) begin
                            state_d = ST_REFUND;
                        end
                    end else begin
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end
            ST_REFUND: begin
                ret_d      = 1'b1;
                coin_rej_d = coin_any;
                credit_d   = credit_q - CREDIT_W'(1);
                if (credit_q == CREDIT_W'(1)) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        // Restock takes precedence over a same-cycle sale decrement.
        if (restock) begin
            stock_d = STOCK_V;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            credit_q   <= '0;
            stock_q    <= STOCK_V;
            coke_out_q <= 1'b0;
            ret_q      <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            stock_q    <= stock_d;
            coke_out_q <= coke_out_d;
            ret_q      <= ret_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign coke_out = coke_out_q;
    assign ret      = ret_q;
    assign coin_rej = coin_rej_q;
    assign credit   = credit_q;
    assign stock    = stock_q;
    assign busy     = (state_q == ST_REFUND);

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param (default parameters).
// A behavioural model tracks credit, stock and owed change as integers;
// one compare process checks every output on each falling edge, and
// directed sequences pin both DUT and model to hand-computed values.
module tb_vend_fsm_param;

    localparam int PRICE      = 5;
    localparam int COIN_SMALL = 1;
    localparam int COIN_LARGE = 2;
    localparam int CREDIT_W   = 4;
    localparam int STOCK_INIT = 8;
    localparam int STOCK_W    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                pay = 1'b0;
    logic                pay_half = 1'b0;
    logic                cancel = 1'b0;
    logic                restock = 1'b0;
    logic                coke_out;
    logic                ret;
    logic                coin_rej;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock;
    logic                sold_out;
    logic                busy;

    int checks = 0;
    int failures = 0;

    vend_fsm_param #(
        .PRICE      (PRICE),
        .COIN_SMALL (COIN_SMALL),
        .COIN_LARGE (COIN_LARGE),
        .CREDIT_W   (CREDIT_W),
        .STOCK_INIT (STOCK_INIT),
        .STOCK_W    (STOCK_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pay      (pay),
        .pay_half (pay_half),
        .cancel   (cancel),
        .restock  (restock),
        .coke_out (coke_out),
        .ret      (ret),
        .coin_rej (coin_rej),
        .credit   (credit),
        .stock    (stock),
        .sold_out (sold_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: owed units are paid out one per cycle before
    // anything else happens; otherwise coins add value until the price is met.
    int m_credit, m_stock, m_owed, m_val, m_tot;
    bit m_coke, m_ret, m_rej;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_credit = 0;
            m_stock  = STOCK_INIT;
            m_owed   = 0;
            m_coke   = 0;
            m_ret    = 0;
            m_rej    = 0;
        end else begin
            m_coke = 0;
            m_ret  = 0;
            m_rej  = 0;
            if (m_owed > 0) begin
                m_ret    = 1;
                m_owed   = m_owed - 1;
                m_credit = m_owed;
                m_rej    = pay || pay_half;
            end else if (cancel && m_credit > 0) begin
                m_owed = m_credit;
                m_rej  = pay || pay_half;
            end else if (m_stock == 0) begin
                m_rej = pay || pay_half;
            end else begin
                m_val = pay ? COIN_LARGE : (pay_half ? COIN_SMALL : 0);
                m_rej = pay && pay_half;
                m_tot = m_credit + m_val;
                if (m_tot >= PRICE) begin
                    m_coke   = 1;
                    m_stock  = m_stock - 1;
                    m_credit = m_tot - PRICE;
                    m_owed   = m_credit;
                end else begin
                    m_credit = m_tot;
                end
            end
            if (restock) m_stock = STOCK_INIT;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp coke_out", int'(coke_out), int'(m_coke));
            chk("cmp ret",      int'(ret),      int'(m_ret));
            chk("cmp coin_rej", int'(coin_rej), int'(m_rej));
            chk("cmp credit",   int'(credit),   m_credit);
            chk("cmp stock",    int'(stock),    m_stock);
            chk("cmp sold_out", int'(sold_out), int'(m_stock == 0));
            chk("cmp busy",     int'(busy),     int'(m_owed > 0));
        end
    end

    // Apply one cycle of inputs (from a falling edge) and wait to the next falling edge.
    task automatic cyc(input bit p, input bit ph, input bit c, input bit rs);
        pay      = p;
        pay_half = ph;
        cancel   = c;
        restock  = rs;
        @(negedge clk);
        pay      = 1'b0;
        pay_half = 1'b0;
        cancel   = 1'b0;
        restock  = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk("reset credit",   int'(credit),   0);
        chk("reset stock",    int'(stock),    8);
        chk("reset coke_out", int'(coke_out), 0);
        chk("reset ret",      int'(ret),      0);
        chk("reset coin_rej", int'(coin_rej), 0);
        chk("reset busy",     int'(busy),     0);
        chk("reset sold_out", int'(sold_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: five small coins make exactly the price
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, 0, 0);
            chk("t1 credit", int'(credit), i);
            chk("t1 ret", int'(ret), 0);
        end
        cyc(0, 1, 0, 0);
        chk("t1 coke_out", int'(coke_out), 1);
        chk("t1 credit0", int'(credit), 0);
        chk("t1 stock", int'(stock), 7);
        chk("t1 model stock", m_stock, 7);
        cyc(0, 0, 0, 0);
        chk("t1 coke_out low", int'(coke_out), 0);
        chk("t1 ret idle", int'(ret), 0);

        // 2: credit 4 plus large coin -> vend with one unit change
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t2 credit4", int'(credit), 4);
        cyc(1, 0, 0, 0);
        chk("t2 coke_out", int'(coke_out), 1);
        chk("t2 credit1", int'(credit), 1);
        chk("t2 busy", int'(busy), 1);
        chk("t2 ret early", int'(ret), 0);
        cyc(0, 0, 0, 0);
        chk("t2 ret", int'(ret), 1);
        chk("t2 credit0", int'(credit), 0);
        chk("t2 busy done", int'(busy), 0);
        chk("t2 model credit", m_credit, 0);
        cyc(0, 0, 0, 0);
        chk("t2 ret once", int'(ret), 0);
        chk("t2 stock", int'(stock), 6);

        // 3: cancel with credit 3 refunds three units; coin during refund bounced
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t3 credit3", int'(credit), 3);
        cyc(0, 0, 1, 0);
        chk("t3 busy", int'(busy), 1);
        chk("t3 credit hold", int'(credit), 3);
        cyc(1, 0, 0, 0);
        chk("t3 ret1", int'(ret), 1);
        chk("t3 credit2", int'(credit), 2);
        chk("t3 coin_rej", int'(coin_rej), 1);
        cyc(0, 0, 0, 0);
        chk("t3 ret2", int'(ret), 1);
        chk("t3 credit1", int'(credit), 1);
        chk("t3 rej clear", int'(coin_rej), 0);
        cyc(0, 0, 0, 0);
        chk("t3 ret3", int'(ret), 1);
        chk("t3 credit0", int'(credit), 0);
        cyc(0, 0, 0, 0);
        chk("t3 ret end", int'(ret), 0);
        chk("t3 busy end", int'(busy), 0);

        // 4: both coins together -> large taken, small bounced
        cyc(1, 1, 0, 0);
        chk("t4 credit2", int'(credit), 2);
        chk("t4 coin_rej", int'(coin_rej), 1);
        chk("t4 model rej", int'(m_rej), 1);
        cyc(1, 0, 0, 0);
        chk("t4 rej pulse", int'(coin_rej), 0);
        cyc(0, 1, 0, 0);
        chk("t4 coke_out", int'(coke_out), 1);
        chk("t4 stock", int'(stock), 5);

        // 5: drain stock to zero, coins locked out, restock reopens
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
            cyc(0, 1, 0, 0);
            chk("t5 vend", int'(coke_out), 1);
        end
        chk("t5 stock0", int'(stock), 0);
        chk("t5 sold_out", int'(sold_out), 1);
        cyc(1, 0, 0, 0);
        chk("t5 rej", int'(coin_rej), 1);
        chk("t5 credit", int'(credit), 0);
        cyc(0, 0, 0, 1);
        chk("t5 restock", int'(stock), 8);
        chk("t5 sold_out off", int'(sold_out), 0);
        cyc(1, 0, 0, 0);
        chk("t5 accept", int'(credit), 2);
        chk("t5 accept rej", int'(coin_rej), 0);

        // 6: asynchronous reset in the middle of a refund
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("t6 ret before", int'(ret), 1);
        chk("t6 credit2", int'(credit), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 ret async", int'(ret), 0);
        chk("t6 credit async", int'(credit), 0);
        chk("t6 busy async", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("t6 no ret", int'(ret), 0);
        end

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(3) == 0, $urandom_range(3) == 0,
                $urandom_range(19) == 0, $urandom_range(59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
